// File: rtl/hit_pkg.sv
// hit_pkg: definitions shared by the hit resolution datapath.
//   - phase encodings as driven by the player state machines
//   - attack kind encodings
//   - box_t and the signed, edge-inclusive box overlap test
// Box edges are carried as 32-bit signed ints. Callers sign-extend their
// narrower coordinates, so a hitbox that lies partly left of x=0 still
// compares correctly.
package hit_pkg;

    localparam logic [1:0] PHASE_IDLE     = 2'b00;
    localparam logic [1:0] PHASE_STARTUP  = 2'b01;
    localparam logic [1:0] PHASE_ACTIVE   = 2'b10;
    localparam logic [1:0] PHASE_RECOVERY = 2'b11;

    localparam logic KIND_LIGHT = 1'b0;
    localparam logic KIND_HEAVY = 1'b1;

    typedef struct packed {
        int x_lo;
        int x_hi;
        int y_lo;
        int y_hi;
    } box_t;

    // Both ranges are closed intervals, so touching edges count as overlap.
    function automatic logic box_overlap(input box_t a, input box_t b);
        return (a.x_lo <= b.x_hi) && (b.x_lo <= a.x_hi) &&
               (a.y_lo <= b.y_hi) && (b.y_lo <= a.y_hi);
    endfunction

endpackage

// File: rtl/hit_channel.sv
// hit_channel: one attacker -> defender direction of hit resolution.
// The channel builds the attacker's hitbox and tests it against the
// defender's hurtbox. It holds the one-connect-per-swing latch and makes the
// raw hit/block decision. Its outputs are combinational; the top level
// registers them.
//   clk_game, reset       game tick clock, async active-high reset
//   atk_*_i               attacker body box, phase, kind, facing
//   atk_stunned_i         attacker stun counter is nonzero (pre-tick value)
//   def_*_i               defender body box, phase, block intent
//   resolve_o             attack connects this tick
//   blocked_o             the connect is a block (only when resolve_o is set)
module hit_channel
    import hit_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int HB_H    = 8,
    parameter int HB_W0   = 32,
    parameter int HB_W1   = 48
) (
    input  logic               clk_game,
    input  logic               reset,
    input  logic [COORD_W-1:0] atk_x_i,
    input  logic [COORD_W-1:0] atk_y_i,
    input  logic [COORD_W-1:0] atk_w_i,
    input  logic [COORD_W-1:0] atk_h_i,
    input  logic [1:0]         atk_phase_i,
    input  logic               atk_kind_i,
    input  logic               atk_facing_right_i,
    input  logic               atk_stunned_i,
    input  logic [COORD_W-1:0] def_x_i,
    input  logic [COORD_W-1:0] def_y_i,
    input  logic [COORD_W-1:0] def_w_i,
    input  logic [COORD_W-1:0] def_h_i,
    input  logic [1:0]         def_phase_i,
    input  logic               def_back_i,
    output logic               resolve_o,
    output logic               blocked_o
);

    // Two extra bits: one for sign, one of headroom for x+w+width sums.
    localparam int CW = COORD_W + 2;
    typedef logic signed [CW-1:0] crd_t;

    localparam crd_t ONE      = crd_t'(1);
    localparam crd_t HBH      = crd_t'(HB_H);
    localparam crd_t HBH_HALF = crd_t'(HB_H / 2);
    localparam crd_t HBW0     = crd_t'(HB_W0);
    localparam crd_t HBW1     = crd_t'(HB_W1);

    function automatic crd_t ext(input logic [COORD_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

    crd_t ax, ay, aw, ah, dx, dy, dw, dh;
    crd_t hbw, hx_lo, hx_hi, hy_lo, hy_hi;
    box_t hit_box, hurt_box;
    logic overlap, atk_active;
    logic connected_q, connected_d;

    assign ax = ext(atk_x_i);
    assign ay = ext(atk_y_i);
    assign aw = ext(atk_w_i);
    assign ah = ext(atk_h_i);
    assign dx = ext(def_x_i);
    assign dy = ext(def_y_i);
    assign dw = ext(def_w_i);
    assign dh = ext(def_h_i);

    assign hbw   = (atk_kind_i == KIND_HEAVY) ? HBW1 : HBW0;
    assign hx_lo = atk_facing_right_i ? (ax + aw) : (ax - hbw);
    assign hx_hi = hx_lo + hbw - ONE;
    // The hitbox is centred vertically on the body; h/2 truncates.
    assign hy_lo = ay + (ah >>> 1) - HBH_HALF;
    assign hy_hi = hy_lo + HBH - ONE;

    assign hit_box  = '{int'(hx_lo), int'(hx_hi), int'(hy_lo), int'(hy_hi)};
    assign hurt_box = '{int'(dx), int'(dx + dw - ONE), int'(dy), int'(dy + dh - ONE)};
    assign overlap  = box_overlap(hit_box, hurt_box);

    assign atk_active = (atk_phase_i == PHASE_ACTIVE);
    assign resolve_o  = atk_active && !connected_q && overlap && !atk_stunned_i;
    // A defender can only block from neutral; any committed phase eats the hit.
    assign blocked_o  = resolve_o && def_back_i && (def_phase_i == PHASE_IDLE);

    // The latch clears as soon as the swing leaves the active window.
    assign connected_d = atk_active && (connected_q || resolve_o);

    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) connected_q <= 1'b0;
        else       connected_q <= connected_d;
    end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: two-player hit resolution on the game tick.
// Two hit_channel instances (P1->P2, P2->P1) make the raw decisions. This
// level owns the stun counters, trade handling and registered event outputs.
//   clk_game, reset                 game tick clock, async active-high reset
//   pN_{x,y,w,h}_i                  body box of player N
//   pN_phase_i, pN_kind_i           attack phase / kind
//   pN_facing_right_i, pN_back_i    hitbox side / block intent
//   p1_hit_p2_o, p2_hit_p1_o        one-tick hit pulses
//   p1_blocked_by_p2_o, p2_blocked_by_p1_o  one-tick block pulses
//   pN_dmg_o                        damage taken by player N this tick
//   pN_stunned_o                    player N stun counter nonzero
module hit_resolver
    import hit_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int HB_H      = 8,
    parameter int HB_W0     = 32,
    parameter int HB_W1     = 48,
    parameter int DMG0      = 5,
    parameter int DMG1      = 12,
    parameter int DMG_W     = 8,
    parameter int HITSTUN   = 12,
    parameter int BLOCKSTUN = 6,
    parameter int STUN_W    = 5
) (
    input  logic               clk_game,
    input  logic               reset,
    input  logic [COORD_W-1:0] p1_x_i,
    input  logic [COORD_W-1:0] p1_y_i,
    input  logic [COORD_W-1:0] p1_w_i,
    input  logic [COORD_W-1:0] p1_h_i,
    input  logic [1:0]         p1_phase_i,
    input  logic               p1_kind_i,
    input  logic               p1_facing_right_i,
    input  logic               p1_back_i,
    input  logic [COORD_W-1:0] p2_x_i,
    input  logic [COORD_W-1:0] p2_y_i,
    input  logic [COORD_W-1:0] p2_w_i,
    input  logic [COORD_W-1:0] p2_h_i,
    input  logic [1:0]         p2_phase_i,
    input  logic               p2_kind_i,
    input  logic               p2_facing_right_i,
    input  logic               p2_back_i,
    output logic               p1_hit_p2_o,
    output logic               p2_hit_p1_o,
    output logic               p1_blocked_by_p2_o,
    output logic               p2_blocked_by_p1_o,
    output logic [DMG_W-1:0]   p1_dmg_o,
    output logic [DMG_W-1:0]   p2_dmg_o,
    output logic               p1_stunned_o,
    output logic               p2_stunned_o
);

    typedef logic [STUN_W-1:0] stun_t;
    typedef logic [DMG_W-1:0]  dmg_t;

    localparam stun_t HIT_LD = stun_t'(HITSTUN);
    localparam stun_t BLK_LD = stun_t'(BLOCKSTUN);
    localparam stun_t ONE    = stun_t'(1);
    localparam dmg_t  D0     = dmg_t'(DMG0);
    localparam dmg_t  D1     = dmg_t'(DMG1);

    logic  r12, b12, r21, b21;
    stun_t p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
    logic  h12_d, h21_d;
    dmg_t  p1_dmg_d, p2_dmg_d;

    // Both channels see the pre-tick counters, so a trade resolves both
    // sides before either stun load lands.
    hit_channel #(.COORD_W(COORD_W), .HB_H(HB_H), .HB_W0(HB_W0), .HB_W1(HB_W1)) u_ch12 (
        .clk_game(clk_game), .reset(reset),
        .atk_x_i(p1_x_i), .atk_y_i(p1_y_i), .atk_w_i(p1_w_i), .atk_h_i(p1_h_i),
        .atk_phase_i(p1_phase_i), .atk_kind_i(p1_kind_i),
        .atk_facing_right_i(p1_facing_right_i), .atk_stunned_i(p1_cnt_q != '0),
        .def_x_i(p2_x_i), .def_y_i(p2_y_i), .def_w_i(p2_w_i), .def_h_i(p2_h_i),
        .def_phase_i(p2_phase_i), .def_back_i(p2_back_i),
        .resolve_o(r12), .blocked_o(b12)
    );

    hit_channel #(.COORD_W(COORD_W), .HB_H(HB_H), .HB_W0(HB_W0), .HB_W1(HB_W1)) u_ch21 (
        .clk_game(clk_game), .reset(reset),
        .atk_x_i(p2_x_i), .atk_y_i(p2_y_i), .atk_w_i(p2_w_i), .atk_h_i(p2_h_i),
        .atk_phase_i(p2_phase_i), .atk_kind_i(p2_kind_i),
        .atk_facing_right_i(p2_facing_right_i), .atk_stunned_i(p2_cnt_q != '0),
        .def_x_i(p1_x_i), .def_y_i(p1_y_i), .def_w_i(p1_w_i), .def_h_i(p1_h_i),
        .def_phase_i(p1_phase_i), .def_back_i(p1_back_i),
        .resolve_o(r21), .blocked_o(b21)
    );

    always_comb begin
        h12_d    = r12 && !b12;
        h21_d    = r21 && !b21;
        p2_dmg_d = h12_d ? ((p1_kind_i == KIND_HEAVY) ? D1 : D0) : '0;
        p1_dmg_d = h21_d ? ((p2_kind_i == KIND_HEAVY) ? D1 : D0) : '0;

        // A load replaces the count outright and wins over the decrement.
        if (r12)                p2_cnt_d = b12 ? BLK_LD : HIT_LD;
        else if (p2_cnt_q != 0) p2_cnt_d = p2_cnt_q - ONE;
        else                    p2_cnt_d = '0;

        if (r21)                p1_cnt_d = b21 ? BLK_LD : HIT_LD;
        else if (p1_cnt_q != 0) p1_cnt_d = p1_cnt_q - ONE;
        else                    p1_cnt_d = '0;
    end

    always_ff @(posedge clk_game or posedge reset) begin
        if (reset) begin
            p1_cnt_q           <= '0;
            p2_cnt_q           <= '0;
            p1_hit_p2_o        <= 1'b0;
            p2_hit_p1_o        <= 1'b0;
            p1_blocked_by_p2_o <= 1'b0;
            p2_blocked_by_p1_o <= 1'b0;
            p1_dmg_o           <= '0;
            p2_dmg_o           <= '0;
            p1_stunned_o       <= 1'b0;
            p2_stunned_o       <= 1'b0;
        end else begin
            p1_cnt_q           <= p1_cnt_d;
            p2_cnt_q           <= p2_cnt_d;
            p1_hit_p2_o        <= h12_d;
            p2_hit_p1_o        <= h21_d;
            p1_blocked_by_p2_o <= b12;
            p2_blocked_by_p1_o <= b21;
            p1_dmg_o           <= p1_dmg_d;
            p2_dmg_o           <= p2_dmg_d;
            // Registered copy of the next count, so it tracks the counter exactly.
            p1_stunned_o       <= (p1_cnt_d != '0);
            p2_stunned_o       <= (p2_cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
module tb_hit_resolver;

    logic       clk_game = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] p1_x, p1_y, p1_w, p1_h, p2_x, p2_y, p2_w, p2_h;
    logic [1:0] p1_phase, p2_phase;
    logic       p1_kind, p2_kind, p1_face, p2_face, p1_back, p2_back;
    logic       h12, h21, b12, b21, s1, s2;
    logic [7:0] d1, d2;

    hit_resolver dut (
        .clk_game(clk_game), .reset(reset),
        .p1_x_i(p1_x), .p1_y_i(p1_y), .p1_w_i(p1_w), .p1_h_i(p1_h),
        .p1_phase_i(p1_phase), .p1_kind_i(p1_kind),
        .p1_facing_right_i(p1_face), .p1_back_i(p1_back),
        .p2_x_i(p2_x), .p2_y_i(p2_y), .p2_w_i(p2_w), .p2_h_i(p2_h),
        .p2_phase_i(p2_phase), .p2_kind_i(p2_kind),
        .p2_facing_right_i(p2_face), .p2_back_i(p2_back),
        .p1_hit_p2_o(h12), .p2_hit_p1_o(h21),
        .p1_blocked_by_p2_o(b12), .p2_blocked_by_p1_o(b21),
        .p1_dmg_o(d1), .p2_dmg_o(d2),
        .p1_stunned_o(s1), .p2_stunned_o(s2)
    );

    always #5 clk_game = ~clk_game;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Hitbox reach computed straight from the box rules with plain ints.
    function automatic bit reach(input int ax, input int ay, input int aw, input int ah,
                                 input bit kind, input bit face,
                                 input int dx, input int dy, input int dw, input int dh);
        int hw, lo, vlo;
        hw  = kind ? 48 : 32;
        lo  = face ? ax + aw : ax - hw;
        vlo = ay + ah / 2 - 4;
        return (lo <= dx + dw - 1) && (dx <= lo + hw - 1) &&
               (vlo <= dy + dh - 1) && (dy <= vlo + 7);
    endfunction

    int  m_con1, m_con2, m_stun1, m_stun2;
    int  e_h12, e_h21, e_b12, e_b21, e_d1, e_d2;
    bit  r12, r21, k12, k21;

    always @(posedge clk_game or posedge reset) begin
        if (reset) begin
            m_con1 = 0; m_con2 = 0; m_stun1 = 0; m_stun2 = 0;
            e_h12 = 0; e_h21 = 0; e_b12 = 0; e_b21 = 0; e_d1 = 0; e_d2 = 0;
        end else begin
            r12 = (p1_phase == 2'b10) && (m_con1 == 0) && (m_stun1 == 0) &&
                  reach(int'(p1_x), int'(p1_y), int'(p1_w), int'(p1_h), p1_kind, p1_face,
                        int'(p2_x), int'(p2_y), int'(p2_w), int'(p2_h));
            r21 = (p2_phase == 2'b10) && (m_con2 == 0) && (m_stun2 == 0) &&
                  reach(int'(p2_x), int'(p2_y), int'(p2_w), int'(p2_h), p2_kind, p2_face,
                        int'(p1_x), int'(p1_y), int'(p1_w), int'(p1_h));
            k12 = r12 && p2_back && (p2_phase == 2'b00);
            k21 = r21 && p1_back && (p1_phase == 2'b00);
            e_h12 = int'(r12 && !k12);
            e_h21 = int'(r21 && !k21);
            e_b12 = int'(k12);
            e_b21 = int'(k21);
            e_d2  = e_h12 != 0 ? (p1_kind ? 12 : 5) : 0;
            e_d1  = e_h21 != 0 ? (p2_kind ? 12 : 5) : 0;
            m_stun2 = r12 ? (k12 ? 6 : 12) : (m_stun2 > 0 ? m_stun2 - 1 : 0);
            m_stun1 = r21 ? (k21 ? 6 : 12) : (m_stun1 > 0 ? m_stun1 - 1 : 0);
            m_con1 = int'((p1_phase == 2'b10) && (m_con1 != 0 || r12));
            m_con2 = int'((p2_phase == 2'b10) && (m_con2 != 0 || r21));
        end
    end

    // Observation tallies for the directed literal checks.
    int n_h12, n_h21, n_b12, n_b21, sum_d1, sum_d2, n_d2, n_s1, n_s2;

    task automatic clear_obs();
        n_h12 = 0; n_h21 = 0; n_b12 = 0; n_b21 = 0;
        sum_d1 = 0; sum_d2 = 0; n_d2 = 0; n_s1 = 0; n_s2 = 0;
    endtask

    always @(posedge clk_game) begin
        #1;
        if (!reset) begin
            check("p1_hit_p2", int'(h12), e_h12);
            check("p2_hit_p1", int'(h21), e_h21);
            check("p1_blocked_by_p2", int'(b12), e_b12);
            check("p2_blocked_by_p1", int'(b21), e_b21);
            check("p1_dmg", int'(d1), e_d1);
            check("p2_dmg", int'(d2), e_d2);
            check("p1_stunned", int'(s1), int'(m_stun1 != 0));
            check("p2_stunned", int'(s2), int'(m_stun2 != 0));
            n_h12 += int'(h12); n_h21 += int'(h21);
            n_b12 += int'(b12); n_b21 += int'(b21);
            sum_d1 += int'(d1); sum_d2 += int'(d2);
            n_d2 += int'(d2 != 0);
            n_s1 += int'(s1); n_s2 += int'(s2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_game);
    endtask

    task automatic setup(input int ax, input bit af, input bit ak,
                         input int bx, input bit bf, input bit bk);
        p1_x = 10'(ax); p1_y = 10'd0; p1_w = 10'd40; p1_h = 10'd40;
        p2_x = 10'(bx); p2_y = 10'd0; p2_w = 10'd40; p2_h = 10'd40;
        p1_face = af; p1_kind = ak; p2_face = bf; p2_kind = bk;
        p1_phase = 2'b00; p2_phase = 2'b00; p1_back = 1'b0; p2_back = 1'b0;
    endtask

    // One P1 swing: n active ticks, one recovery tick, then idle long enough
    // for any stun to drain.
    task automatic p1_swing(input int n);
        p1_phase = 2'b10; tick(n);
        p1_phase = 2'b11; tick(1);
        p1_phase = 2'b00; tick(16);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h12"}, int'(h12), 0);
        check({tag, "_h21"}, int'(h21), 0);
        check({tag, "_b12"}, int'(b12), 0);
        check({tag, "_b21"}, int'(b21), 0);
        check({tag, "_d1"}, int'(d1), 0);
        check({tag, "_d2"}, int'(d2), 0);
        check({tag, "_s1"}, int'(s1), 0);
        check({tag, "_s2"}, int'(s2), 0);
    endtask

    initial begin
        setup(100, 1, 0, 150, 0, 0);
        reset = 1'b1;
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Close hit, light, 3-tick active window.
        clear_obs();
        p1_swing(3);
        check("t1_hit_count", n_h12, 1);
        check("t1_block_count", n_b12, 0);
        check("t1_dmg_sum", sum_d2, 5);
        check("t1_dmg_ticks", n_d2, 1);
        check("t1_stun_ticks", n_s2, 12);

        // Defender holding back from idle blocks.
        clear_obs();
        p2_back = 1'b1;
        p1_swing(3);
        check("t2_block_count", n_b12, 1);
        check("t2_hit_count", n_h12, 0);
        check("t2_dmg_sum", sum_d2, 0);
        check("t2_stun_ticks", n_s2, 6);

        // Holding back during startup cannot block.
        clear_obs();
        p2_phase = 2'b01;
        p1_swing(3);
        check("t2b_hit_count", n_h12, 1);
        check("t2b_block_count", n_b12, 0);
        check("t2b_dmg_sum", sum_d2, 5);
        p2_phase = 2'b00; p2_back = 1'b0;

        // Range by kind: light misses, heavy connects.
        setup(100, 1, 0, 180, 0, 0);
        clear_obs();
        p1_swing(3);
        check("t3_light_events", n_h12 + n_b12, 0);
        check("t3_light_stun", n_s2, 0);
        p1_kind = 1'b1;
        clear_obs();
        p1_swing(3);
        check("t3_heavy_hit", n_h12, 1);
        check("t3_heavy_dmg", sum_d2, 12);

        // Facing-left hitbox extending below zero.
        setup(0, 1, 0, 20, 0, 1);
        p1_w = 10'd16;
        clear_obs();
        p2_phase = 2'b10; tick(3);
        p2_phase = 2'b00; tick(16);
        check("t4_hit_count", n_h21, 1);
        check("t4_dmg_sum", sum_d1, 12);
        check("t4_stun_ticks", n_s1, 12);
        // A wrapped hitbox would reach a player at x=1000.
        p1_x = 10'd1000;
        clear_obs();
        p2_phase = 2'b10; tick(3);
        p2_phase = 2'b00; tick(4);
        check("t4_no_wrap", n_h21 + n_b21, 0);

        // Trade, then a second P1 swing while stunned.
        setup(100, 1, 0, 150, 0, 1);
        clear_obs();
        p1_phase = 2'b10; p2_phase = 2'b10; tick(1);
        p1_phase = 2'b11; p2_phase = 2'b11; tick(1);
        p2_phase = 2'b00;
        p1_swing(3);
        check("t5_p1_hits", n_h12, 1);
        check("t5_p2_hits", n_h21, 1);
        check("t5_p2_dmg", sum_d2, 5);
        check("t5_p1_dmg", sum_d1, 12);
        check("t5_p1_stun", n_s1, 12);
        check("t5_p2_stun", n_s2, 12);

        // Reset while P2's counter sits at 7, with P1 still active.
        setup(100, 1, 0, 150, 0, 0);
        clear_obs();
        p1_phase = 2'b10;
        tick(6);
        check("t6_pre_stun", int'(s2), 1);
        #1 reset = 1'b1;
        #1 check_all_zero("t6_rst");
        #1 reset = 1'b0;
        clear_obs();
        tick(1);
        check("t6_rehit", n_h12, 1);
        check("t6_rehit_dmg", sum_d2, 5);
        p1_phase = 2'b00;
        tick(16);
        check("t6_hits_total", n_h12, 1);
        check("t6_stun_ticks", n_s2, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
# hit_resolver

Parametrised two-player hit resolution for the fighting-game datapath, running on the game tick. It generalises the previous single-shot hit check with attack kinds (per-kind hitbox width and damage), facing direction, multi-frame active windows with one-connect-per-swing latching, hitstun/blockstun counters, and explicit trade handling. It sits between the two player state machines and the health/animation logic. It consumes positions and attack phase, and emits registered event pulses, damage and stun levels.

## Interface
- COORD_W, 10, coordinate/size width
- HB_H, 8, hitbox height (all kinds)
- HB_W0 / HB_W1, 32 / 48, hitbox width for kind 0 (light) / kind 1 (heavy)
- DMG0 / DMG1, 5 / 12, damage for kind 0 / kind 1
- DMG_W, 8, damage output width
- HITSTUN, 12, hitstun ticks; BLOCKSTUN, 6, blockstun ticks
- STUN_W, 5, stun counter width (must hold max(HITSTUN, BLOCKSTUN))
- clk_game  in  1  game tick clock
- reset  in  1  asynchronous, active-high
- pN_x, pN_y, pN_w, pN_h  in  COORD_W each  body box of player N (N=1,2), unsigned
- pN_phase  in  2  00 idle, 01 startup, 10 active, 11 recovery
- pN_kind  in  1  attack kind, held for the whole swing
- pN_facing_right  in  1  hitbox side
- pN_back  in  1  player holding away (block intent)
- p1_hit_p2, p2_hit_p1  out  1  one-tick hit pulse
- p1_blocked_by_p2, p2_blocked_by_p1  out  1  one-tick block pulse
- p1_dmg, p2_dmg  out  DMG_W  damage taken by that player this tick, 0 otherwise
- p1_stunned, p2_stunned  out  1  stun counter nonzero

## Operation
- Hurtbox of N: [x, x+w-1] × [y, y+h-1].
- Hitbox of N, width HBW=HB_W[kind]: facing right [x+w, x+w+HBW-1]; facing left [x-HBW, x-1]; vertical [y+h/2-HB_H/2, top+HB_H-1].
- All box arithmetic is signed, COORD_W+2 bits. Negative/over-range edges do not wrap and compare correctly. Overlap is inclusive on all four edges.
- Per attacker, a `connected` latch. Resolution happens on any tick where all of these hold:
  - phase==active
  - connected==0
  - overlap
  - the attacker's own stun counter is 0 (stunned attackers never connect)
- On resolution, connected is set. It clears on any tick where phase!=active, so there is exactly one connect per swing, anywhere inside the active window.
- Block vs hit: the hit is blocked if defender_back==1 and defender phase==idle. Otherwise it is a hit.
  - Blocked: block pulse, dmg 0, defender counter loaded BLOCKSTUN.
  - Hit: hit pulse, dmg=DMG[kind], defender counter loaded HITSTUN.
- Loading replaces the current value (no accumulation). A stunned defender can still be hit or block.
- Trade: both resolve on the same tick. Both events fire and both counters load. Each attacker's stun check uses the pre-tick counter value.
- Stun counters decrement by 1 per tick when nonzero and saturate at 0. A load takes priority over a decrement.

## Timing
- All outputs are registered. Inputs sampled at edge k produce pulses and dmg during cycle k..k+1 only; they are 0 at edge k+1 unless a new resolution occurs.
- pN_stunned rises in the same cycle as the pulse and stays high for exactly HITSTUN (or BLOCKSTUN) ticks.
- Reset, asynchronous, clears every output, both latches and both counters to 0.
  - Reset mid-swing: after release, if phase is still active, connect is permitted again on the first eligible tick.
- Kind or facing changes during the active window are used as sampled; they are not re-latched.

## Structure
- Package hit_pkg holds:
  - phase localparams (PHASE_IDLE/STARTUP/ACTIVE/RECOVERY)
  - kind encodings
  - the signed box-overlap function
- Sub-module hit_channel is instantiated twice (P1→P2, P2→P1). It contains hitbox generation, the overlap test, the connected latch, and the raw hit/block decision.
- The top level holds the stun counters, trade handling and output registers.

## Test plan
- Close hit, 3-tick active window: P1 x=100,w=40,facing right,kind 0; P2 x=150,w=40, idle, back=0.
  - Required: p1_hit_p2 pulses once, p2_dmg=5 for one tick, p2_stunned high for exactly 12 ticks.
- Block: same setup, P2 back=1 → p1_blocked_by_p2 pulse, p2_dmg=0, p2_stunned high 6 ticks.
  - P2 back=1 but phase=startup → hit instead, dmg=5.
- Range by kind: P2 x=180.
  - Kind 0 (hitbox 140..171) → no event.
  - Kind 1 (140..187) → hit, dmg=12.
- Facing-left underflow: P2 x=20, facing left, kind 1; P1 x=0,w=16.
  - Hitbox -28..19 overlaps, so hit.
  - Must not wrap to 1000+.
- Trade: both active with overlapping hitboxes on the same tick → all four hit outputs resolve correctly, both dmg nonzero, both stunned 12 ticks.
  - A second swing by P1 while p1_stunned=1 → no event.
- Reset asserted mid-stun (counter=7) → outputs 0 immediately.
  - Active phase still held after release → a new hit fires on the next tick.
